// File: rtl/anc_pkg.sv
// Shared types and constants for the ANC audio path (sample format, I2S frame geometry).
// Latency: n/a (package only).
// Backpressure: n/a; provides sample_t, FRAME_SLOTS, WORD_BITS, SLOT_W, i2s_state_t and mono_frame().
package anc_pkg;

  // One audio sample as produced by the FIR stage.
  typedef logic signed [15:0] sample_t;

  // I2S frame: 32 bit-clock slots, two 16-bit words (left then right).
  localparam int FRAME_SLOTS = 32;
  localparam int WORD_BITS   = 16;
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } i2s_state_t;

  // Mono frame image: the same sample in the left and right words, left first.
  function automatic logic [2*WORD_BITS-1:0] mono_frame(input sample_t s);
    return {s, s};
  endfunction

endpackage

// File: rtl/i2s_transmitter_bclk_gen.sv
// Bit-clock divider: bclk toggles every CLK_DIV clk cycles; fall_strobe marks the cycle that drives bclk low.
// Latency: first bclk rise CLK_DIV cycles after reset release; fall_strobe is combinational from the divider state.
// Backpressure: none; free-running whenever reset is released.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   bclk         divided bit clock (registered)
//   fall_strobe  high during the clk cycle whose rising edge drives bclk from 1 to 0
module bclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk,
  output logic fall_strobe
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;
  logic       terminal;

  assign terminal    = (div_cnt == DIV_LAST);
  // The edge that ends a high half-period is the one that pulls bclk low.
  assign fall_strobe = terminal & bclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= 8'd0;
      bclk    <= 1'b0;
    end else if (terminal) begin
      div_cnt <= 8'd0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// Mono I2S transmitter: one pending sample slot feeds a 32-slot frame (left = right = sample), MSB first, 1-bit delay.
// Latency: a sample is latched at the next frame start (slot 0 falling edge); left MSB appears one slot later.
// Backpressure: none; a second sample before consumption overwrites the pending one and sets sticky overrun_out.
//
// Ports:
//   clk_in       system clock, rising edge
//   rst_in       asynchronous active-low reset
//   ready_in     one-cycle strobe, signal_in valid
//   signal_in    signed 16-bit sample
//   bclk_out     I2S bit clock
//   lrclk_out    word select, 0 = left (slots 0..15), 1 = right (slots 16..31)
//   sdata_out    serial data, changes only on bclk falling edges
//   done_out     one-cycle pulse when a pending sample is taken into a frame
//   overrun_out  sticky, set when a pending sample is overwritten unconsumed
//
// Build option: I2S_TX_UNDERRUN_ZERO_EN -- when defined, an underrun frame carries zero;
// otherwise the last transmitted sample is repeated (zero after reset).
module i2s_transmitter
  import anc_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               ready_in,
  input  logic signed [15:0] signal_in,
  output logic               bclk_out,
  output logic               lrclk_out,
  output logic               sdata_out,
  output logic               done_out,
  output logic               overrun_out
);

  i2s_state_t state_q;
  i2s_state_t state_d;
  logic       run;

  logic bclk_raw;
  logic fall_strobe;

  logic [SLOT_W-1:0]      slot_q;
  logic [SLOT_W-1:0]      slot_next;
  logic                   framing_q;
  logic                   slot_tick;
  logic                   frame_start;
  logic                   consume;
  logic [2*WORD_BITS-1:0] shreg_q;

  sample_t pending_q;
  logic    pending_vld_q;
  sample_t frame_sample;

`ifndef I2S_TX_UNDERRUN_ZERO_EN
  sample_t last_q;
`endif

  bclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_bclk_gen (
    .clk        (clk_in),
    .rst_n      (rst_in),
    .bclk       (bclk_raw),
    .fall_strobe(fall_strobe)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN: begin
        state_d = ST_RUN;
        run     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // IDLE keeps the bit clock off the pins even though the divider is already counting.
  assign bclk_out = run & bclk_raw;

  // ---------------------------------------------------------------- slot timing
  assign slot_tick = run & fall_strobe;

  // Before the first falling edge no frame is in flight, so that edge starts slot 0
  // rather than advancing from the reset value.
  assign slot_next   = framing_q ? (slot_q + 1'b1) : '0;
  assign frame_start = slot_tick & (~framing_q | (slot_q == SLOT_W'(FRAME_SLOTS - 1)));
  assign consume     = frame_start & pending_vld_q;

  always_comb begin
    frame_sample = pending_q;
    if (!pending_vld_q) begin
`ifdef I2S_TX_UNDERRUN_ZERO_EN
      frame_sample = '0;
`else
      frame_sample = last_q;
`endif
    end
  end

  // ---------------------------------------------------------------- serialiser
  // sdata for slot k is the bit at the top of the shifter when slot k begins.
  // At a frame start the top bit is still right[0] of the previous frame (the
  // one-bit I2S delay); the new frame is loaded on the same edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      slot_q    <= '0;
      framing_q <= 1'b0;
      lrclk_out <= 1'b0;
      sdata_out <= 1'b0;
      shreg_q   <= '0;
      done_out  <= 1'b0;
    end else begin
      done_out <= consume;
      if (slot_tick) begin
        slot_q    <= slot_next;
        framing_q <= 1'b1;
        lrclk_out <= (int'(slot_next) >= WORD_BITS);
        sdata_out <= shreg_q[2*WORD_BITS-1];
        if (frame_start) begin
          shreg_q <= mono_frame(frame_sample);
        end else begin
          shreg_q <= {shreg_q[2*WORD_BITS-2:0], 1'b0};
        end
      end
    end
  end

  // ---------------------------------------------------------------- pending sample
  // A strobe on the consume cycle refills the slot after the old value has
  // been taken, so it is not an overrun.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
      overrun_out   <= 1'b0;
    end else begin
      if (ready_in) begin
        pending_q     <= signal_in;
        pending_vld_q <= 1'b1;
        if (pending_vld_q && !consume) begin
          overrun_out <= 1'b1;
        end
      end else if (consume) begin
        pending_vld_q <= 1'b0;
      end
    end
  end

`ifndef I2S_TX_UNDERRUN_ZERO_EN
  // Remembers what the last fed frame carried, for repeat on underrun.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      last_q <= '0;
    end else if (consume) begin
      last_q <= pending_q;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_transmitter.sv
`timescale 1ns/1ps
module tb_i2s_transmitter;

  localparam int CLK_DIV     = 4;
  localparam int BCLK_PER    = 2 * CLK_DIV;
  localparam int WAIT_BUDGET = 2 * 32 * BCLK_PER + 16;

  logic               clk_in    = 1'b0;
  logic               rst_in    = 1'b1;
  logic               ready_in  = 1'b0;
  logic signed [15:0] signal_in = '0;
  logic               bclk_out;
  logic               lrclk_out;
  logic               sdata_out;
  logic               done_out;
  logic               overrun_out;

  i2s_transmitter #(.CLK_DIV(CLK_DIV)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .ready_in   (ready_in),
    .signal_in  (signal_in),
    .bclk_out   (bclk_out),
    .lrclk_out  (lrclk_out),
    .sdata_out  (sdata_out),
    .done_out   (done_out),
    .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: one entry per sample expected to be consumed into a frame.
  logic [15:0] exp_q[$];
  int          exp_done = 0;
  logic [15:0] model_last = '0;

  // Monitor state.
  int          mon_slot = 0;
  logic        mon_rise = 1'b0;
  bit          started = 0, in_frame = 0, have_rise = 0;
  bit          frame_consumed = 0, next_consumed = 0;
  logic        prev_bclk = 1'b0, prev_sd = 1'b0, prev_lr = 1'b0;
  logic [31:0] acc = '0;
  int          cyc_since_rise = 0;
  int          done_cnt = 0, stray_done = 0, lr_err = 0, sd_err = 0, per_err = 0, frames_cmp = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Decode the serial stream at negedge clk, away from the DUT's active edge.
  always @(negedge clk_in) begin
    logic [31:0] got_w;
    logic [15:0] e;
    mon_rise = 1'b0;
    if (!rst_in) begin
      started = 0; in_frame = 0; have_rise = 0;
      frame_consumed = 0; next_consumed = 0;
      prev_bclk = 1'b0; prev_sd = 1'b0; prev_lr = 1'b0;
      acc = '0; cyc_since_rise = 0; mon_slot = 0;
      exp_q.delete();
      model_last = '0;
    end else begin
      cyc_since_rise++;
      if (prev_bclk && !bclk_out) begin
        if (!started) begin
          started  = 1;
          mon_slot = 0;
        end else begin
          mon_slot = (mon_slot + 1) % 32;
        end
        if (mon_slot == 0) next_consumed = done_out;
        else if (done_out) stray_done++;
        if (done_out) done_cnt++;
        if (lrclk_out !== (mon_slot >= 16)) lr_err++;
      end else begin
        if (done_out) begin
          stray_done++;
          done_cnt++;
        end
        if (sdata_out !== prev_sd || lrclk_out !== prev_lr) sd_err++;
      end
      if (!prev_bclk && bclk_out) begin
        if (have_rise && cyc_since_rise != BCLK_PER) per_err++;
        have_rise      = 1;
        cyc_since_rise = 0;
        mon_rise       = 1'b1;
        if (started) begin
          if (mon_slot == 0) begin
            if (in_frame) begin
              got_w = {acc[30:0], sdata_out};
              if (frame_consumed) begin
                if (exp_q.size() == 0) begin
                  check("frame_done_without_sample", 32'd1, 32'd0);
                end else begin
                  e = exp_q.pop_front();
                  model_last = e;
                  check("frame_data", got_w, {e, e});
                  frames_cmp++;
                end
              end else begin
`ifdef I2S_TX_UNDERRUN_ZERO_EN
                e = 16'h0000;
`else
                e = model_last;
`endif
                check("frame_underrun", got_w, {e, e});
                frames_cmp++;
              end
            end
            in_frame       = 1;
            frame_consumed = next_consumed;
            acc            = '0;
          end else begin
            acc = {acc[30:0], sdata_out};
          end
        end
      end
      prev_bclk = bclk_out;
      prev_sd   = sdata_out;
      prev_lr   = lrclk_out;
    end
  end

  task automatic wait_rise(input int slot);
    int n;
    n = 0;
    forever begin
      @(negedge clk_in);
      #1;
      if (started && mon_rise && mon_slot == slot) return;
      n++;
      if (n > WAIT_BUDGET) begin
        checks++;
        failures++;
        $display("FAIL wait_slot%0d: no bclk rise in that slot within %0d cycles, expected one", slot, WAIT_BUDGET);
        return;
      end
    end
  endtask

  task automatic next_frame();
    wait_rise(1);
    wait_rise(0);
  endtask

  task automatic send(input logic [15:0] v);
    ready_in  = 1'b1;
    signal_in = v;
    @(negedge clk_in);
    #1;
    ready_in = 1'b0;
  endtask

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
    exp_done++;
  endtask

  task automatic release_and_measure(input string name);
    int n;
    @(negedge clk_in);
    #1;
    rst_in = 1'b1;
    n = 0;
    while (!bclk_out && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    check(name, n, CLK_DIV);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_in = 1'b0;
    #20;
    check("reset_outputs", {27'd0, bclk_out, lrclk_out, sdata_out, done_out, overrun_out}, 32'd0);
    release_and_measure("first_bclk_rise_cycles");

    // Basic frame, then an underrun frame.
    wait_rise(5);
    send(16'h8001);
    push(16'h8001);
    next_frame();
    next_frame();

    // Underrun after 7FFF.
    wait_rise(5);
    send(16'h7FFF);
    push(16'h7FFF);
    next_frame();
    next_frame();

    // New sample on the consume cycle.
    wait_rise(5);
    send(16'h1111);
    push(16'h1111);
    wait_rise(31);
    repeat (CLK_DIV - 1) @(negedge clk_in);
    #1;
    push(16'h00FF);
    send(16'h00FF);
    next_frame();
    check("overrun_after_simultaneous", {31'd0, overrun_out}, 32'd0);

    // Overrun within one frame.
    wait_rise(3);
    send(16'h1234);
    wait_rise(10);
    send(16'h5678);
    push(16'h5678);
    check("overrun_set", {31'd0, overrun_out}, 32'd1);
    next_frame();

    // Reset in slot 9 with a sample pending.
    wait_rise(3);
    send(16'h4321);
    push(16'h4321);
    next_frame();
    wait_rise(9);
    send(16'h2222);
    #1;
    rst_in = 1'b0;
    #1;
    check("midframe_reset_bclk", {31'd0, bclk_out}, 32'd0);
    check("midframe_reset_lrclk", {31'd0, lrclk_out}, 32'd0);
    check("midframe_reset_sdata", {31'd0, sdata_out}, 32'd0);
    check("midframe_reset_done", {31'd0, done_out}, 32'd0);
    check("midframe_reset_overrun", {31'd0, overrun_out}, 32'd0);
    repeat (3) @(negedge clk_in);
    release_and_measure("bclk_rise_after_midframe_reset");
    next_frame();
    next_frame();
    next_frame();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("done_pulse_count", done_cnt, exp_done);
    check("done_outside_slot0", stray_done, 32'd0);
    check("lrclk_slot_errors", lr_err, 32'd0);
    check("data_change_off_bclk_fall", sd_err, 32'd0);
    check("bclk_period_errors", per_err, 32'd0);
    check("frames_compared_at_least_10", {31'd0, frames_cmp >= 10}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
